// File: rtl/mul8_seq.sv
// Sequential 8x8 unsigned shift-add multiplier with IDLE/RUN/DONE handshake.
// Optional macro MUL8_SEQ_ZERO_SKIP_EN: a zero operand bypasses RUN straight to DONE.

module adder8b (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic c;

  always_comb begin
    sum = '0;
    c   = cin;
    for (int unsigned i = 0; i < 8; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end
endmodule

module mux8b (
  input  logic       sel,
  input  logic [7:0] d0,
  input  logic [7:0] d1,
  output logic [7:0] y
);
  always_comb y = sel ? d1 : d0;
endmodule

module mul8_seq (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic        Ack,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] P
);
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state;
  logic [7:0]  m, q, h;
  logic [2:0]  cnt;
  logic        busy_r, done_r;
  logic [7:0]  addend, sum;
  logic        carry;

  mux8b u_mux (.sel(q[0]), .d0(8'h00), .d1(m), .y(addend));
  adder8b u_add (.a(h), .b(addend), .cin(1'b0), .sum(sum), .cout(carry));

`ifdef MUL8_SEQ_ZERO_SKIP_EN
  logic zero_op;
  always_comb zero_op = (A == 8'h00) || (B == 8'h00);
`endif

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state  <= IDLE;
      m      <= '0;
      q      <= '0;
      h      <= '0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
`ifdef MUL8_SEQ_ZERO_SKIP_EN
            if (zero_op) begin
              m      <= A;
              q      <= '0;
              h      <= '0;
              cnt    <= '0;
              state  <= DONE;
              done_r <= 1'b1;
            end else
`endif
            begin
              m      <= A;
              q      <= B;
              h      <= '0;
              cnt    <= '0;
              state  <= RUN;
              busy_r <= 1'b1;
            end
          end
        end
        RUN: begin
          // 17-bit {carry,sum,q} right shift: low product bits replace consumed multiplier bits
          {h, q} <= {carry, sum, q[7:1]};
          cnt    <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        DONE: begin
          if (Ack) begin
            state  <= IDLE;
            done_r <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign Busy = busy_r;
  assign Done = done_r;
  assign P    = {h, q};
endmodule

// File: tb/tb_mul8_seq.sv
// Randomized self-checking bench for mul8_seq against an arithmetic product/latency model.
module tb_mul8_seq;
  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Start = 1'b0;
  logic [7:0]  A = '0;
  logic [7:0]  B = '0;
  logic        Ack = 1'b0;
  logic        Busy, Done;
  logic [15:0] P;

  int checks = 0;
  int errors = 0;

`ifdef MUL8_SEQ_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  mul8_seq dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .A(A), .B(B),
    .Ack(Ack), .Busy(Busy), .Done(Done), .P(P)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
    return (ZS && (a == 8'd0 || b == 8'd0)) ? 1 : 9;
  endfunction

  // Issues one Start, scrambles operands afterwards, and waits (bounded) for Done.
  task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                         output int lat, output int busy_cycles, output int overlap,
                         output logic [15:0] p);
    A = a; B = b; Start = 1'b1;
    tick();
    Start = 1'b0;
    A = 8'($urandom); B = 8'($urandom);
    lat = 1; busy_cycles = 0; overlap = 0;
    while (!Done && lat < 20) begin
      if (Busy) busy_cycles++;
      tick();
      lat++;
    end
    if (Busy && Done) overlap++;
    p = P;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; Start = 1'b1; Ack = 1'b0; A = 8'd9; B = 8'd9;
    tick(); tick();
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Done); end
    checks++; if (P !== 16'h0000) begin errors++; $display("FAIL reset_p got %h want 0000", P); end
    Start = 1'b0; Rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat, bc, ov; logic [15:0] p;
    Ack = 1'b1;
    run_mul(8'd13, 8'd11, lat, bc, ov, p);
    checks++; if (lat !== 9) begin errors++; $display("FAIL basic_lat got %0d want 9", lat); end
    checks++; if (bc !== 8) begin errors++; $display("FAIL basic_busy got %0d want 8", bc); end
    checks++; if (p !== 16'h008F) begin errors++; $display("FAIL basic_p got %h want 008f", p); end
    tick();
    checks++; if (Done !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL basic_idle got busy=%b done=%b want 0 0", Busy, Done); end
  endtask

  task automatic test_hold();
    int lat, bc, ov; logic [15:0] p;
    Ack = 1'b0;
    run_mul(8'd255, 8'd255, lat, bc, ov, p);
    for (int i = 0; i < 5; i++) begin
      checks++; if (Done !== 1'b1 || P !== 16'hFE01) begin errors++; $display("FAIL hold_%0d got done=%b p=%h want 1 fe01", i, Done, P); end
      tick();
    end
    Ack = 1'b1;
    tick();
    checks++; if (Done !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL hold_release got busy=%b done=%b want 0 0", Busy, Done); end
  endtask

  task automatic test_ignore_start();
    int cyc;
    Ack = 1'b1;
    A = 8'd7; B = 8'd9; Start = 1'b1;
    tick(); Start = 1'b0;
    tick();
    A = 8'd2; B = 8'd3; Start = 1'b1;
    tick(); Start = 1'b0;
    cyc = 3;
    while (!Done && cyc < 20) begin tick(); cyc++; end
    checks++; if (cyc !== 9) begin errors++; $display("FAIL ign_lat got %0d want 9", cyc); end
    checks++; if (P !== 16'h003F) begin errors++; $display("FAIL ign_p got %h want 003f", P); end
    A = 8'd2; B = 8'd3; Start = 1'b1;
    tick(); Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL ign_norun_%0d got busy=%b done=%b want 0 0", i, Busy, Done); end
      tick();
    end
  endtask

  task automatic test_reset_abort();
    int lat, bc, ov; logic [15:0] p;
    Ack = 1'b1;
    A = 8'd200; B = 8'd150; Start = 1'b1;
    tick(); Start = 1'b0;
    repeat (4) tick();
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
    checks++; if (Busy !== 1'b0 || Done !== 1'b0 || P !== 16'h0000) begin errors++; $display("FAIL abort got busy=%b done=%b p=%h want 0 0 0000", Busy, Done, P); end
    run_mul(8'd5, 8'd6, lat, bc, ov, p);
    checks++; if (lat !== 9 || p !== 16'h001E) begin errors++; $display("FAIL abort_rerun got lat=%0d p=%h want 9 001e", lat, p); end
    tick();
  endtask

  task automatic test_zero();
    int lat, bc, ov; logic [15:0] p;
    logic [7:0] za [2];
    logic [7:0] zb [2];
    za[0] = 8'd0;  zb[0] = 8'd77;
    za[1] = 8'd77; zb[1] = 8'd0;
    Ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      run_mul(za[i], zb[i], lat, bc, ov, p);
      checks++; if (lat !== exp_lat(za[i], zb[i]) || p !== 16'h0000) begin errors++; $display("FAIL zero_%0d got lat=%0d p=%h want %0d 0000", i, lat, p, exp_lat(za[i], zb[i])); end
      checks++; if (bc !== exp_lat(za[i], zb[i]) - 1) begin errors++; $display("FAIL zero_busy_%0d got %0d want %0d", i, bc, exp_lat(za[i], zb[i]) - 1); end
      tick();
    end
  endtask

  task automatic test_random();
    int lat, bc, ov; logic [15:0] p;
    logic [7:0] a, b;
    Ack = 1'b1;
    for (int i = 0; i < 400; i++) begin
      case (i)
        0: begin a = 8'd255; b = 8'd1;   end
        1: begin a = 8'd1;   b = 8'd255; end
        2: begin a = 8'd128; b = 8'd128; end
        3: begin a = 8'd0;   b = 8'd0;   end
        default: begin a = 8'($urandom); b = 8'($urandom); end
      endcase
      run_mul(a, b, lat, bc, ov, p);
      checks++; if (p !== 16'(a * b)) begin errors++; $display("FAIL rand_p a=%0d b=%0d got %h want %h", a, b, p, 16'(a * b)); end
      checks++; if (lat !== exp_lat(a, b)) begin errors++; $display("FAIL rand_lat a=%0d b=%0d got %0d want %0d", a, b, lat, exp_lat(a, b)); end
      checks++; if (ov !== 0) begin errors++; $display("FAIL rand_overlap a=%0d b=%0d busy and done both high", a, b); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_ignore_start();
    test_reset_abort();
    test_zero();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul8_seq.md
MUL8_SEQ -- requirements
Module: mul8_seq

Interface
REQ-001 Parameters: none; operand width fixed at 8 bits, product width at 16 bits.
REQ-002 Clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Rst_n  input  1  reset; synchronous, active-low.
REQ-004 Start  input  1  request a multiplication; sampled only in IDLE.
REQ-005 A  input  8  multiplicand, unsigned; captured on an accepted Start.
REQ-006 B  input  8  multiplier, unsigned; captured on an accepted Start.
REQ-007 Ack  input  1  consumer has taken P; sampled only in DONE.
REQ-008 Busy  output  1  high exactly while the state is RUN.
REQ-009 Done  output  1  high exactly while the state is DONE; P is valid.
REQ-010 P  output  16  unsigned product A*B.

Function
REQ-011 The FSM SHALL have three states, IDLE, RUN and DONE, encoded in 2 bits; the unused code SHALL go to IDLE on the next edge.
REQ-012 IDLE with Start=1: M<=A, Q<=B, H<=0, Cnt<=0, next state RUN; otherwise remain in IDLE.
REQ-013 RUN, each cycle: {C,S} = H + (Q[0] ? M : 0); then {H,Q} <= {C,S,Q[7:1]}, which is a 17-bit right shift; Cnt <= Cnt+1.
REQ-014 The add SHALL use the library adder8b with Cin=0, and the operand select SHALL use the library mux8b; no behavioural '+' or '*' is allowed in the datapath.
REQ-015 RUN SHALL last exactly 8 cycles (Cnt 0..7); the edge ending the Cnt=7 cycle SHALL move to DONE.
REQ-016 P SHALL equal {H,Q} in every state; it SHALL hold stable throughout DONE.
REQ-017 Latency: Start is sampled high at edge 0, Busy is high for cycles 1-8, and Done is first high in cycle 9.
REQ-018 DONE with Ack=1: next state IDLE; with Ack=0: remain in DONE indefinitely with P unchanged.
REQ-019 Start in RUN or DONE SHALL be ignored, with no capture and no queueing; a Start that coincides with Ack in DONE SHALL also be ignored.
REQ-020 Ack outside DONE SHALL be ignored.
REQ-021 A and B may change freely after the capture edge without affecting the result.
REQ-022 Busy and Done SHALL never be high together; both SHALL be low in IDLE.

Reset
REQ-023 Rst_n=0 at an edge SHALL force state IDLE, M=0, Q=0, H=0, Cnt=0; hence Busy=0, Done=0, P=16'h0000 from the following cycle.
REQ-024 Reset SHALL take priority over Start and Ack, and it SHALL abort RUN or DONE at any cycle, discarding any partial result.
REQ-025 The first Start accepted after Rst_n returns high SHALL behave exactly as from power-up.

Configuration
REQ-026 Macro MUL8_SEQ_ZERO_SKIP_EN.
REQ-027 Defined: in IDLE, when Start=1 and (A==0 or B==0), the block SHALL load H=0 and Q=0 and go directly to DONE, so Done is high in cycle 1 with P=0 and Busy never asserts.
REQ-028 Not defined: zero operands SHALL take the full 8-cycle RUN, with Done in cycle 9 and P=0; no zero-detect logic shall be synthesized.

Verification
REQ-029 Reset, then A=13, B=11, Start for 1 cycle, Ack tied high -> Busy cycles 1-8, Done only in cycle 9 with P=16'h008F, IDLE in cycle 10.
REQ-030 A=255, B=255, Ack held low for 5 cycles after Done -> P=16'hFE01 stable and Done high for all 5 cycles, then IDLE the cycle after Ack.
REQ-031 Start re-pulsed with A=2, B=3 during RUN of 7*9, and again in DONE coincident with Ack -> P=16'h003F; no second RUN begins.
REQ-032 Rst_n low for 1 cycle during the RUN cycle with Cnt=4 -> Busy=0, Done=0, P=0 next cycle; a new 5*6 run -> P=16'h001E at cycle 9.
REQ-033 A=0, B=77 -> with MUL8_SEQ_ZERO_SKIP_EN, Done in cycle 1 with P=0; without it, Done in cycle 9 with P=0.
REQ-034 Exhaustive sweep of all 65536 (A,B) pairs, Ack high -> P==A*B each time, Done exactly 9 cycles after Start (1 cycle when zero-skip is enabled and an operand is 0).
